// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide stage. It runs one radix-2
// iteration per clock and produces a single write-back pulse for the register file.
//
// Ports:
//   CLK, RST      rising-edge clock; synchronous active-high reset
//   Start         request, sampled only while idle
//   Op            00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   Operand_a     multiplicand / dividend
//   Operand_b     multiplier / divisor
//   Dest_reg      destination register index
//   Busy          high while the unit is not idle
//   Write_enable  one-cycle result strobe; suppressed when the destination is register 0
//   Write_reg     destination index of the last result (held)
//   Write_data    last result (held)
module mul_div_unit #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned ADDR_BITS = 5
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [DATA_BITS-1:0] Operand_a,
   input  logic [DATA_BITS-1:0] Operand_b,
   input  logic [ADDR_BITS-1:0] Dest_reg,
   output logic                 Busy,
   output logic                 Write_enable,
   output logic [ADDR_BITS-1:0] Write_reg,
   output logic [DATA_BITS-1:0] Write_data
);

   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [1:0] OpMul   = 2'd0;
   localparam logic [1:0] OpMulhu = 2'd1;
   localparam logic [1:0] OpDivu  = 2'd2;
   localparam logic [1:0] OpRemu  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [1:0]           op_q, op_d;
   logic [ADDR_BITS-1:0] dest_q, dest_d;
   // addend: multiplicand for MUL*, divisor for DIV*.
   logic [DATA_BITS-1:0] addend_q, addend_d;
   // hi: accumulator high half / partial remainder.
   // lo: multiplier bits being consumed / dividend bits shifting into the quotient.
   logic [DATA_BITS-1:0] hi_q, hi_d;
   logic [DATA_BITS-1:0] lo_q, lo_d;
   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] wreg_q, wreg_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;

   // One shift-add step: add the multiplicand when the multiplier LSB is set,
   // then shift the whole 2N-bit accumulator right by one.
   logic [DATA_BITS:0]   mul_sum;
   logic [DATA_BITS-1:0] mul_hi, mul_lo;

   // One restoring-divide step: shift the next dividend bit into the remainder,
   // then keep the difference only if it did not go negative.
   logic [DATA_BITS:0]   div_shift, div_diff;
   logic                 div_ok;
   logic [DATA_BITS-1:0] div_hi, div_lo;

   logic                 last_iter;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
      mul_hi    = mul_sum[DATA_BITS:1];
      mul_lo    = {mul_sum[0], lo_q[DATA_BITS-1:1]};

      div_shift = {hi_q, lo_q[DATA_BITS-1]};
      div_diff  = div_shift - {1'b0, addend_q};
      div_ok    = ~div_diff[DATA_BITS];
      div_hi    = div_ok ? div_diff[DATA_BITS-1:0] : div_shift[DATA_BITS-1:0];
      div_lo    = {lo_q[DATA_BITS-2:0], div_ok};

      last_iter = (count_q == CNT_W'(DATA_BITS - 1));
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      dest_d   = dest_q;
      addend_d = addend_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      we_d     = we_q;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;

      case (state_q)
         StIdle: begin
            if (Start) begin
               op_d    = Op;
               dest_d  = Dest_reg;
               count_d = '0;
               if (Op[1] && (Operand_b == '0)) begin
                  // Divide by zero: the result is known now, so skip the iterations.
                  state_d = StDone;
                  wdata_d = (Op == OpDivu) ? '1 : Operand_a;
                  wreg_d  = Dest_reg;
                  we_d    = (Dest_reg != '0);
               end else begin
                  state_d = StRun;
                  hi_d    = '0;
                  if (Op[1]) begin
                     addend_d = Operand_b;
                     lo_d     = Operand_a;
                  end else begin
                     addend_d = Operand_a;
                     lo_d     = Operand_b;
                  end
               end
            end
         end
         StRun: begin
            count_d = count_q + 1'b1;
            if (op_q[1]) begin
               hi_d = div_hi;
               lo_d = div_lo;
            end else begin
               hi_d = mul_hi;
               lo_d = mul_lo;
            end
            if (last_iter) begin
               state_d = StDone;
               wreg_d  = dest_q;
               we_d    = (dest_q != '0);
               case (op_q)
                  OpMul:   wdata_d = mul_lo;
                  OpMulhu: wdata_d = mul_hi;
                  OpDivu:  wdata_d = div_lo;
                  OpRemu:  wdata_d = div_hi;
                  default: wdata_d = mul_lo;
               endcase
            end
         end
         StDone: begin
            we_d    = 1'b0;
            state_d = StIdle;
         end
         default: begin
            we_d    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         count_q  <= '0;
         op_q     <= '0;
         dest_q   <= '0;
         addend_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         we_q     <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         dest_q   <= dest_d;
         addend_q <= addend_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         we_q     <= we_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
      end
   end

   assign Busy         = (state_q != StIdle);
   assign Write_enable = we_q;
   assign Write_reg    = wreg_q;
   assign Write_data   = wdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] Operand_a;
   logic [31:0] Operand_b;
   logic [4:0]  Dest_reg;
   logic        Busy;
   logic        Write_enable;
   logic [4:0]  Write_reg;
   logic [31:0] Write_data;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(
      .DATA_BITS(32),
      .ADDR_BITS(5)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .Start       (Start),
      .Op          (Op),
      .Operand_a   (Operand_a),
      .Operand_b   (Operand_b),
      .Dest_reg    (Dest_reg),
      .Busy        (Busy),
      .Write_enable(Write_enable),
      .Write_reg   (Write_reg),
      .Write_data  (Write_data)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request and watch 41 samples (index 0 = just after the accept edge).
   // exp_idx < 0 means no Write_enable pulse is expected.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest,
                         input logic [31:0] exp_data, input int exp_idx,
                         input int exp_busy, input bit pulse);
      int we_cnt;
      int we_idx;
      int busy_cnt;
      we_cnt   = 0;
      we_idx   = -1;
      busy_cnt = 0;
      @(negedge CLK);
      Op        = op;
      Operand_a = a;
      Operand_b = b;
      Dest_reg  = dest;
      Start     = 1'b1;
      @(posedge CLK);
      #1;
      Start     = 1'b0;
      // Scramble inputs to prove the latched copies are used.
      Op        = ~op;
      Operand_a = 32'hDEAD_BEEF;
      Operand_b = 32'h0BAD_F00D;
      Dest_reg  = ~dest;
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            @(posedge CLK);
            #1;
         end
         if (Busy) busy_cnt++;
         if (Write_enable) begin
            we_cnt++;
            if (we_idx < 0) we_idx = i;
         end
         Start = pulse && (i == 5 || i == 20);
      end
      Start = 1'b0;
      check($sformatf("%s busy_cycles", name), 64'(busy_cnt), 64'(exp_busy));
      if (exp_idx >= 0) begin
         check($sformatf("%s we_count", name), 64'(we_cnt), 64'd1);
         check($sformatf("%s we_latency", name), 64'(we_idx), 64'(exp_idx));
      end else begin
         check($sformatf("%s we_count", name), 64'(we_cnt), 64'd0);
      end
      check($sformatf("%s write_reg", name), 64'(Write_reg), 64'(dest));
      check($sformatf("%s write_data", name), 64'(Write_data), 64'(exp_data));
   endtask

   initial begin
      int we_seen;
      RST       = 1'b1;
      Start     = 1'b1;  // reset must win over a request
      Op        = 2'b00;
      Operand_a = 32'd1;
      Operand_b = 32'd1;
      Dest_reg  = 5'd1;
      repeat (3) @(posedge CLK);
      #1;
      check("reset busy", 64'(Busy), 64'd0);
      check("reset we", 64'(Write_enable), 64'd0);
      check("reset write_reg", 64'(Write_reg), 64'd0);
      check("reset write_data", 64'(Write_data), 64'd0);
      @(negedge CLK);
      RST   = 1'b0;
      Start = 1'b0;

      run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 32, 33, 1'b0);
      run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 32, 33, 1'b0);
      run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 32, 33, 1'b0);
      run_op("divu100_7", 2'b10, 32'd100, 32'd7, 5'd6, 32'd14, 32, 33, 1'b0);
      run_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'd7, 32'd2, 32, 33, 1'b0);
      run_op("divu5_9", 2'b10, 32'd5, 32'd9, 5'd8, 32'd0, 32, 33, 1'b0);
      run_op("remu5_9", 2'b11, 32'd5, 32'd9, 5'd9, 32'd5, 32, 33, 1'b0);
      run_op("divu_by0", 2'b10, 32'h1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 0, 1, 1'b0);
      run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 5'd11, 32'h0000_1234, 0, 1, 1'b0);
      run_op("mul_ignored_start", 2'b00, 32'd12, 32'd11, 5'd12, 32'd132, 32, 33, 1'b1);
      run_op("mul_dest0", 2'b00, 32'd5, 32'd5, 5'd0, 32'd25, -1, 33, 1'b0);

      // Reset in the middle of a divide: nothing may be written back.
      we_seen = 0;
      @(negedge CLK);
      Op        = 2'b10;
      Operand_a = 32'd1000;
      Operand_b = 32'd3;
      Dest_reg  = 5'd13;
      Start     = 1'b1;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge CLK);
         #1;
         if (Write_enable) we_seen++;
      end
      @(negedge CLK);
      RST   = 1'b1;
      Start = 1'b1;
      @(posedge CLK);
      #1;
      if (Write_enable) we_seen++;
      check("midrst busy", 64'(Busy), 64'd0);
      check("midrst we", 64'(Write_enable), 64'd0);
      check("midrst write_reg", 64'(Write_reg), 64'd0);
      check("midrst write_data", 64'(Write_data), 64'd0);
      check("midrst no_pulse", 64'(we_seen), 64'd0);
      @(negedge CLK);
      RST   = 1'b0;
      Start = 1'b0;

      run_op("mul3x3_after_rst", 2'b00, 32'd3, 32'd3, 5'd14, 32'd9, 32, 33, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
